decoder_scan_sel: RTL and testbench
===================================

// Module: decoder_scan_sel
// PURPOSE
//  Parametrised registered N-to-NUM_OUT one-hot select decoder for the next generation of select decoders.
//  Two modes: DIRECT registers the one-hot decode of sel; SCAN walks a one-hot token over outputs
//  0..NUM_OUT-1 at a programmable rate, for display-digit or bank scanning.
//  Sits between control logic and the enables of register banks or display digits.
//  out is never multi-hot: always exactly one bit set, or all zero.
// PARAMETERS
//  SEL_W    3   select width; NUM_OUT must be <= 2**SEL_W
//  NUM_OUT  8   number of active outputs; out width; the index wraps at NUM_OUT-1
//  DIV_W    16  prescaler counter / div_max width
// PORTS
//  clock    in   1        rising-edge clock
//  reset_n  in   1        synchronous reset, active-low
//  en       in   1        block enable; 0 -> outputs off
//  mode     in   1        0 = DIRECT, 1 = SCAN
//  sel      in   SEL_W    DIRECT-mode index
//  div_max  in   DIV_W    SCAN dwell = div_max+1 cycles per output
//  hold     in   1        SCAN freeze: counter and index hold
//  out      out  NUM_OUT  registered one-hot output
//  cur_idx  out  SEL_W    index currently driven (registered)
//  oob      out  1        DIRECT sel >= NUM_OUT (registered)
//  wrap     out  1        1-cycle pulse when the SCAN index wraps NUM_OUT-1 -> 0
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge), highest priority, overrides all inputs:
//   out=0, cur_idx=0, oob=0, wrap=0, prescaler=0, state=IDLE.
//  States: IDLE, DIRECT, SCAN. Next state is evaluated every edge:
//   en=0 -> IDLE; en=1 & mode=0 -> DIRECT; en=1 & mode=1 -> SCAN.
//  IDLE: out=0, oob=0, wrap=0, prescaler=0; cur_idx holds.
//  DIRECT: 1-cycle latency; sel sampled at edge k is visible on out after edge k.
//   sel<NUM_OUT: out=1<<sel, cur_idx=sel, oob=0.
//   sel>=NUM_OUT: out=0, oob=1, cur_idx holds. wrap=0.
//  SCAN entry (previous state was not SCAN): cur_idx=0, out=1, prescaler=0, wrap=0, oob=0.
//  SCAN steady, hold=1: prescaler, cur_idx and out all freeze; wrap=0.
//  SCAN steady, hold=0:
//   prescaler<div_max -> prescaler+1.
//   Otherwise: prescaler=0; cur_idx=(cur_idx==NUM_OUT-1)?0:cur_idx+1; out=1<<new cur_idx;
//    wrap=1 only on that same edge when cur_idx goes NUM_OUT-1 -> 0.
//  div_max=0 -> the token advances every cycle.
//  div_max is sampled live: lowering it below the current prescaler value forces an advance on the next edge.
//  Prescaler arithmetic is unsigned DIV_W bits; compare with >= so it never wraps past div_max.
//  Mode switch mid-operation: the new mode takes effect on the next edge. SCAN re-entry always restarts at index 0.
//  en and hold both asserted: en has priority (en=0 -> IDLE regardless of hold).
// TESTING
//  1 Reset: reset_n=0 for 2 cycles with en=1, mode=1 -> out=0, cur_idx=0, oob=0, wrap=0.
//  2 DIRECT: en=1, mode=0, sel=5 -> next cycle out=8'h20, cur_idx=5; then sel=7 -> out=8'h80.
//  3 OOB: NUM_OUT=6, sel=6 -> out=6'h00, oob=1; then sel=2 -> out=6'h04, oob=0.
//  4 SCAN: div_max=2, NUM_OUT=8 -> out sequence 01,02,04,...,80,01, each value held 3 cycles;
//    wrap=1 for exactly the one cycle where out becomes 01 again.
//  5 Hold: div_max=0, assert hold at out=08 for 4 cycles -> out stays 08; release -> out=10 next edge.
//  6 Reset mid-op: reset_n=0 while SCAN at idx 5 -> out=0 next edge; after release with mode=1 -> out=01, cur_idx=0.

Source files
------------

// File: rtl/decoder_scan_sel.sv
// Registered one-hot select decoder with a DIRECT index mode and a SCAN mode that walks
// a single token across the outputs at a programmable dwell rate.

// Structural properties of the decoder outputs, kept apart from the datapath.
module decoder_scan_sel_chk #(
    parameter int NUM_OUT = 8
) (
    input logic               clock,
    input logic               reset_n,
    input logic [NUM_OUT-1:0] out,
    input logic               oob,
    input logic               wrap
);

    a_never_multi_hot : assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(out));

    a_wrap_lands_on_zero : assert property (@(posedge clock) disable iff (!reset_n)
        wrap |-> (out == {{(NUM_OUT-1){1'b0}}, 1'b1}));

    a_oob_blanks_out : assert property (@(posedge clock) disable iff (!reset_n)
        oob |-> (out == {NUM_OUT{1'b0}}));

endmodule

module decoder_scan_sel #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DIV_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DIV_W-1:0]   div_max,
    input  logic               hold,
    output logic [NUM_OUT-1:0] out,
    output logic [SEL_W-1:0]   cur_idx,
    output logic               oob,
    output logic               wrap
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_OUT - 1);
    localparam logic [SEL_W:0]   NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [NUM_OUT-1:0] out_r;
    logic [NUM_OUT-1:0] out_nxt_s;
    logic [SEL_W-1:0]   idx_r;
    logic [SEL_W-1:0]   idx_nxt_s;
    logic [SEL_W-1:0]   idx_adv_s;
    logic               oob_r;
    logic               oob_nxt_s;
    logic               wrap_r;
    logic               wrap_nxt_s;
    logic [DIV_W-1:0]   presc_r;
    logic [DIV_W-1:0]   presc_nxt_s;
    logic               sel_in_range_s;

    function automatic logic [NUM_OUT-1:0] onehot_f(input logic [SEL_W-1:0] idx);
        logic [NUM_OUT-1:0] res;
        res = {NUM_OUT{1'b0}};
        for (int i = 0; i < NUM_OUT; i++) begin
            res[i] = (idx == SEL_W'(i));
        end
        return res;
    endfunction

    assign idx_adv_s      = (idx_r == LAST_IDX) ? {SEL_W{1'b0}} : (idx_r + SEL_W'(1));
    assign sel_in_range_s = ({1'b0, sel} < NUM_OUT_EXT);

    // Mode selection and next-value computation for every registered output.
    always_comb begin
        state_nxt_s = state_r;
        out_nxt_s   = out_r;
        idx_nxt_s   = idx_r;
        oob_nxt_s   = 1'b0;
        wrap_nxt_s  = 1'b0;
        presc_nxt_s = presc_r;

        if (!en) begin
            state_nxt_s = ST_IDLE;
        end else if (mode) begin
            state_nxt_s = ST_SCAN;
        end else begin
            state_nxt_s = ST_DIRECT;
        end

        case (state_nxt_s)
            ST_IDLE: begin
                out_nxt_s   = {NUM_OUT{1'b0}};
                presc_nxt_s = {DIV_W{1'b0}};
            end
            ST_DIRECT: begin
                presc_nxt_s = {DIV_W{1'b0}};
                if (sel_in_range_s) begin
                    out_nxt_s = onehot_f(sel);
                    idx_nxt_s = sel;
                end else begin
                    out_nxt_s = {NUM_OUT{1'b0}};
                    oob_nxt_s = 1'b1;
                end
            end
            ST_SCAN: begin
                // A fresh entry into SCAN always restarts the token at output 0.
                if (state_r != ST_SCAN) begin
                    idx_nxt_s   = {SEL_W{1'b0}};
                    out_nxt_s   = onehot_f({SEL_W{1'b0}});
                    presc_nxt_s = {DIV_W{1'b0}};
                end else if (hold) begin
                    presc_nxt_s = presc_r;
                end else if (presc_r >= div_max) begin
                    presc_nxt_s = {DIV_W{1'b0}};
                    idx_nxt_s   = idx_adv_s;
                    out_nxt_s   = onehot_f(idx_adv_s);
                    wrap_nxt_s  = (idx_r == LAST_IDX);
                end else begin
                    presc_nxt_s = presc_r + DIV_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                out_nxt_s   = {NUM_OUT{1'b0}};
                presc_nxt_s = {DIV_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            out_r   <= {NUM_OUT{1'b0}};
            idx_r   <= {SEL_W{1'b0}};
            oob_r   <= 1'b0;
            wrap_r  <= 1'b0;
            presc_r <= {DIV_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            out_r   <= out_nxt_s;
            idx_r   <= idx_nxt_s;
            oob_r   <= oob_nxt_s;
            wrap_r  <= wrap_nxt_s;
            presc_r <= presc_nxt_s;
        end
    end

    assign out     = out_r;
    assign cur_idx = idx_r;
    assign oob     = oob_r;
    assign wrap    = wrap_r;

    decoder_scan_sel_chk #(
        .NUM_OUT(NUM_OUT)
    ) u_chk (
        .clock   (clock),
        .reset_n (reset_n),
        .out     (out_r),
        .oob     (oob_r),
        .wrap    (wrap_r)
    );

endmodule

// File: tb/tb_decoder_scan_sel.sv
// Scoreboard bench for decoder_scan_sel: an 8-output and a 6-output instance share stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_decoder_scan_sel;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        en;
    logic        mode;
    logic        hold;
    logic [2:0]  sel;
    logic [15:0] div_max;

    logic [7:0]  out8;
    logic [2:0]  idx8;
    logic        oob8;
    logic        wrap8;
    logic [5:0]  out6;
    logic [2:0]  idx6;
    logic        oob6;
    logic        wrap6;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    decoder_scan_sel dut8 (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel),
        .div_max(div_max), .hold(hold), .out(out8), .cur_idx(idx8), .oob(oob8), .wrap(wrap8)
    );

    decoder_scan_sel #(.NUM_OUT(6)) dut6 (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel),
        .div_max(div_max), .hold(hold), .out(out6), .cur_idx(idx6), .oob(oob6), .wrap(wrap6)
    );

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] idx;
        logic       oob;
        logic       wrap;
    } exp_t;

    // Model state: mode kind (0 idle, 1 direct, 2 scan), token index, cycles spent at it.
    typedef struct {
        int st;
        int idx;
        int cnt;
        int outv;
        bit oob;
        bit wrap;
    } mdl_t;

    exp_t q8[$];
    exp_t q6[$];
    mdl_t m8;
    mdl_t m6;

    function automatic mdl_t mstep(mdl_t m, int n);
        mdl_t r = m;
        r.wrap = 1'b0;
        if (!reset_n) begin
            r.st = 0; r.idx = 0; r.cnt = 0; r.outv = 0; r.oob = 1'b0;
        end else if (!en) begin
            r.st = 0; r.cnt = 0; r.outv = 0; r.oob = 1'b0;
        end else if (!mode) begin
            r.st = 1;
            r.cnt = 0;
            if (int'(sel) < n) begin
                r.idx = int'(sel); r.outv = 1 << sel; r.oob = 1'b0;
            end else begin
                r.outv = 0; r.oob = 1'b1;
            end
        end else if (m.st != 2) begin
            r.st = 2; r.idx = 0; r.cnt = 0; r.outv = 1; r.oob = 1'b0;
        end else if (hold) begin
            r.cnt = m.cnt;
        end else if (m.cnt < int'(div_max)) begin
            r.cnt = m.cnt + 1;
        end else begin
            r.cnt  = 0;
            r.wrap = (m.idx == n - 1);
            r.idx  = (m.idx + 1) % n;
            r.outv = 1 << r.idx;
        end
        return r;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        return exp_t'{8'(m.outv), 3'(m.idx), m.oob, m.wrap};
    endfunction

    task automatic step();
        m8 = mstep(m8, 8);
        m6 = mstep(m6, 6);
        @(posedge clock);
        q8.push_back(to_exp(m8));
        q6.push_back(to_exp(m6));
        #1;
    endtask

    // Monitor: pops one expectation per instance per cycle and compares away from the edge.
    always @(negedge clock) begin
        exp_t e;
        exp_t got;
        if (q8.size() > 0) begin
            e   = q8.pop_front();
            got = {out8, idx8, oob8, wrap8};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL n8_outputs t=%0t got out=%h idx=%0d oob=%b wrap=%b exp out=%h idx=%0d oob=%b wrap=%b",
                         $time, got.out, got.idx, got.oob, got.wrap, e.out, e.idx, e.oob, e.wrap);
            end
            total++;
            if (!$onehot0(out8)) begin
                bad++;
                $display("FAIL n8_onehot t=%0t got out=%h exp at most one bit", $time, out8);
            end
        end
        if (q6.size() > 0) begin
            e   = q6.pop_front();
            got = {2'b00, out6, idx6, oob6, wrap6};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL n6_outputs t=%0t got out=%h idx=%0d oob=%b wrap=%b exp out=%h idx=%0d oob=%b wrap=%b",
                         $time, got.out, got.idx, got.oob, got.wrap, e.out, e.idx, e.oob, e.wrap);
            end
        end
    end

    initial begin
        m8 = '{default: 0};
        m6 = '{default: 0};
        reset_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 3'd0; div_max = 16'd0; hold = 1'b0;
        repeat (2) step();

        // DIRECT decode, including out-of-range on the 6-output instance.
        reset_n = 1'b1; mode = 1'b0;
        sel = 3'd5; step();
        sel = 3'd7; step();
        sel = 3'd6; step();
        sel = 3'd2; step();

        // SCAN with a three-cycle dwell, past one full wrap.
        mode = 1'b1; div_max = 16'd2;
        repeat (28) step();

        // Hold while the token sits on output 3, then release.
        div_max = 16'd0; mode = 1'b0; step();
        mode = 1'b1; step();
        repeat (3) step();
        hold = 1'b1; repeat (4) step();
        hold = 1'b0; repeat (2) step();

        // Reset in the middle of a scan, then re-enter SCAN.
        mode = 1'b0; step();
        mode = 1'b1; step();
        repeat (5) step();
        reset_n = 1'b0; step();
        reset_n = 1'b1; repeat (3) step();

        // Lowering div_max below the running prescaler forces an advance.
        div_max = 16'd6; repeat (5) step();
        div_max = 16'd1; repeat (3) step();

        // Randomised phase with sticky modes so scans run long enough to wrap.
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) div_max = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 199) == 0) div_max = 16'($urandom_range(0, 65535));
            sel  = 3'($urandom_range(0, 7));
            hold = ($urandom_range(0, 5) == 0);
            step();
        end

        repeat (2) @(posedge clock);
        total++;
        if (q8.size() != 0 || q6.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d/%0d exp 0/0", q8.size(), q6.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
